rep_seq_monitor: RTL and testbench



---
 rtl/rep_seq_monitor.sv | 242 ++++++++++++++++++++++++
 tb/tb_rep_seq_monitor.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rep_seq_monitor.sv
// rep_seq_monitor
//
// Run-time checker for the sequence "a, then b repeated CNT times, then c".
// This is the synthesizable counterpart of the repetition assertions used in
// simulation. It can sit in silicon or emulation next to the logic it
// watches.
//
// Repetition flavours (MODE):
//   0 = goto            [->CNT]  b hits may be spread out; c checked on the
//                                 CNTth hit
//   1 = non-consecutive [=CNT]   like goto, but c must keep holding after the
//                                 CNTth hit until another b arrives
//   2 = consecutive     [*CNT]   b must hold on every edge; the first gap
//                                 ends the attempt vacuously
//
// Up to NUM_TRK attempts can be in flight at once. Each one lives in its own
// tracker, which holds a state, an 8-bit hit count and an age counter.
//
// Ports:
//   clk       sole clock, rising edge
//   rst       synchronous, active-high reset
//   en        monitor enable; low aborts every attempt silently
//   a         trigger (antecedent start)
//   b         repeated event
//   c         consequent
//   pass      one-cycle pulse: at least one attempt passed at the last edge
//   fail      one-cycle pulse: at least one attempt failed at the last edge
//   vac       one-cycle pulse: at least one attempt ended vacuously
//   ovf       sticky: a trigger was dropped because no tracker was free
//   busy      per-tracker live bits (post-edge state)
//   pass_cnt  saturating count of passing attempts
//   fail_cnt  saturating count of failing attempts

module rep_seq_monitor #(
  parameter int CNT     = 3,
  parameter int MODE    = 1,
  parameter int NUM_TRK = 4,
  parameter int TIMEOUT = 64,
  parameter int CW      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               a,
  input  logic               b,
  input  logic               c,
  output logic               pass,
  output logic               fail,
  output logic               vac,
  output logic               ovf,
  output logic [NUM_TRK-1:0] busy,
  output logic [CW-1:0]      pass_cnt,
  output logic [CW-1:0]      fail_cnt
);

  // Tracker states.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_COUNT  = 2'd1;
  localparam logic [1:0] ST_WINDOW = 2'd2;

  // The age counter only has to reach TIMEOUT-1. With the limit disabled it
  // wraps harmlessly, and a single bit is enough.
  localparam int            AW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [AW-1:0] AGE_LAST = AW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [7:0] CNT_L = 8'(CNT);

  // Width of the per-edge outcome tally. The sum width is chosen so that
  // counter + tally can never wrap before the saturation check.
  localparam int              SW      = $clog2(NUM_TRK + 1);
  localparam int              SUMW    = ((CW > SW) ? CW : SW) + 1;
  localparam logic [SUMW-1:0] SAT_MAX = SUMW'({CW{1'b1}});

  logic [1:0]    state_q [NUM_TRK];
  logic [1:0]    state_d [NUM_TRK];
  logic [7:0]    hits_q  [NUM_TRK];
  logic [7:0]    hits_d  [NUM_TRK];
  logic [AW-1:0] age_q   [NUM_TRK];
  logic [AW-1:0] age_d   [NUM_TRK];

  logic [NUM_TRK-1:0] arm_sel;
  logic               arm_ok;
  logic [NUM_TRK-1:0] pass_t;
  logic [NUM_TRK-1:0] fail_t;
  logic [NUM_TRK-1:0] vac_t;

  logic [SW-1:0]   n_pass;
  logic [SW-1:0]   n_fail;
  logic [SUMW-1:0] pass_sum;
  logic [SUMW-1:0] fail_sum;
  logic [CW-1:0]   pass_cnt_d;
  logic [CW-1:0]   fail_cnt_d;

  // Pick the lowest-index tracker that is idle before this edge.
  // A tracker that finishes on this edge still shows its live state here.
  // That makes a tracker freed at edge t unavailable until edge t+1.
  always_comb begin
    arm_ok  = 1'b0;
    arm_sel = '0;
    for (int i = 0; i < NUM_TRK; i++) begin
      if (!arm_ok && (state_q[i] == ST_IDLE)) begin
        arm_ok     = 1'b1;
        arm_sel[i] = 1'b1;
      end
    end
  end

  // Per-tracker evaluation of the sampled b/c.
  //
  // A normal pass/fail/vac decision is made first. The timeout is applied
  // only if the tracker is still undecided. Disable and arming are handled
  // last.
  //
  // A newly armed tracker was idle at this edge, so the b that arrives with
  // its trigger never counts for it. This gives the ##1 behaviour.
  always_comb begin
    logic [7:0] hit_next;
    logic       timed_out;
    hit_next  = '0;
    timed_out = 1'b0;
    pass_t    = '0;
    fail_t    = '0;
    vac_t     = '0;
    for (int i = 0; i < NUM_TRK; i++) begin
      state_d[i] = state_q[i];
      hits_d[i]  = hits_q[i];
      age_d[i]   = age_q[i];
      hit_next   = hits_q[i] + 8'd1;
      timed_out  = (TIMEOUT != 0) && (age_q[i] == AGE_LAST);
      case (state_q[i])
        ST_COUNT: begin
          age_d[i] = age_q[i] + AW'(1);
          if (b) begin
            hits_d[i] = hit_next;
            if (hit_next == CNT_L) begin
              if ((MODE == 1) && c) begin
                state_d[i] = ST_WINDOW;
              end else begin
                pass_t[i]  = c;
                fail_t[i]  = ~c;
                state_d[i] = ST_IDLE;
              end
            end
          end else if (MODE == 2) begin
            vac_t[i]   = 1'b1;
            state_d[i] = ST_IDLE;
          end
          if (timed_out && !(pass_t[i] || fail_t[i] || vac_t[i])) begin
            vac_t[i]   = 1'b1;
            state_d[i] = ST_IDLE;
          end
        end
        ST_WINDOW: begin
          age_d[i] = age_q[i] + AW'(1);
          if (b) begin
            pass_t[i] = 1'b1;
          end else if (!c) begin
            fail_t[i] = 1'b1;
          end else if (timed_out) begin
            pass_t[i] = 1'b1;
          end
          if (pass_t[i] || fail_t[i]) begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_IDLE: begin
          state_d[i] = ST_IDLE;
        end
        default: begin
          state_d[i] = ST_IDLE;
        end
      endcase
      if (!en) begin
        state_d[i] = ST_IDLE;
        pass_t[i]  = 1'b0;
        fail_t[i]  = 1'b0;
        vac_t[i]   = 1'b0;
      end else if (a && arm_sel[i]) begin
        state_d[i] = ST_COUNT;
        hits_d[i]  = '0;
        age_d[i]   = '0;
      end
    end
  end

  // Count how many trackers produced each outcome on this edge.
  // Add the tally to the running counters, clamping at all-ones.
  always_comb begin
    n_pass = '0;
    n_fail = '0;
    for (int i = 0; i < NUM_TRK; i++) begin
      n_pass = n_pass + SW'(pass_t[i]);
      n_fail = n_fail + SW'(fail_t[i]);
    end
    pass_sum   = SUMW'(pass_cnt) + SUMW'(n_pass);
    fail_sum   = SUMW'(fail_cnt) + SUMW'(n_fail);
    pass_cnt_d = (pass_sum > SAT_MAX) ? {CW{1'b1}} : pass_sum[CW-1:0];
    fail_cnt_d = (fail_sum > SAT_MAX) ? {CW{1'b1}} : fail_sum[CW-1:0];
  end

  // Register tracker state and every output.
  // Reset drops in-flight attempts without reporting them.
  // While en is low the tally is zero, so the counters hold their values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TRK; i++) begin
        state_q[i] <= ST_IDLE;
        hits_q[i]  <= '0;
        age_q[i]   <= '0;
      end
      pass     <= 1'b0;
      fail     <= 1'b0;
      vac      <= 1'b0;
      ovf      <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_TRK; i++) begin
        state_q[i] <= state_d[i];
        hits_q[i]  <= hits_d[i];
        age_q[i]   <= age_d[i];
      end
      pass     <= |pass_t;
      fail     <= |fail_t;
      vac      <= |vac_t;
      pass_cnt <= pass_cnt_d;
      fail_cnt <= fail_cnt_d;
      if (en && a && !arm_ok) begin
        ovf <= 1'b1;
      end
    end
  end

  // Live bits are a direct decode of the registered tracker states.
  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_TRK; i++) begin
      busy[i] = (state_q[i] != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_rep_seq_monitor.sv
// tb_rep_seq_monitor
//
// Bench for rep_seq_monitor. Five differently parameterised instances run
// one scenario at a time.
//
// Expected outcome pulses are queued together with the edge they belong to.
// A negedge monitor pops the queue whenever an instance raises
// pass/fail/vac. Status outputs are compared against hand-computed
// constants.
//
// Instances:
//   d0  MODE1 CNT3 NUM_TRK4 TIMEOUT64 CW16
//   d1  MODE2 CNT3
//   d2  MODE0 CNT3
//   d3  MODE1 CNT3 TIMEOUT8
//   d4  MODE0 CNT1 CW2

module tb_rep_seq_monitor;

  localparam int ND = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [ND-1:0] en_v;
  logic [ND-1:0] a_v;
  logic [ND-1:0] b_v;
  logic [ND-1:0] c_v;
  logic [ND-1:0] pass_v;
  logic [ND-1:0] fail_v;
  logic [ND-1:0] vac_v;
  logic [ND-1:0] ovf_v;

  logic [3:0]  busy0, busy1, busy2, busy3, busy4;
  logic [15:0] pcnt0, pcnt1, pcnt2, pcnt3;
  logic [15:0] fcnt0, fcnt1, fcnt2, fcnt3;
  logic [1:0]  pcnt4, fcnt4;

  int edge_no = 0;
  int base    = 0;
  int total   = 0;
  int bad     = 0;

  typedef struct {
    int   dut;
    int   edge_at;
    logic p;
    logic f;
    logic v;
  } exp_t;

  exp_t sbq[$];

  rep_seq_monitor #(.CNT(3), .MODE(1), .NUM_TRK(4), .TIMEOUT(64), .CW(16)) u_d0 (
    .clk(clk), .rst(rst), .en(en_v[0]), .a(a_v[0]), .b(b_v[0]), .c(c_v[0]),
    .pass(pass_v[0]), .fail(fail_v[0]), .vac(vac_v[0]), .ovf(ovf_v[0]),
    .busy(busy0), .pass_cnt(pcnt0), .fail_cnt(fcnt0));

  rep_seq_monitor #(.CNT(3), .MODE(2), .NUM_TRK(4), .TIMEOUT(64), .CW(16)) u_d1 (
    .clk(clk), .rst(rst), .en(en_v[1]), .a(a_v[1]), .b(b_v[1]), .c(c_v[1]),
    .pass(pass_v[1]), .fail(fail_v[1]), .vac(vac_v[1]), .ovf(ovf_v[1]),
    .busy(busy1), .pass_cnt(pcnt1), .fail_cnt(fcnt1));

  rep_seq_monitor #(.CNT(3), .MODE(0), .NUM_TRK(4), .TIMEOUT(64), .CW(16)) u_d2 (
    .clk(clk), .rst(rst), .en(en_v[2]), .a(a_v[2]), .b(b_v[2]), .c(c_v[2]),
    .pass(pass_v[2]), .fail(fail_v[2]), .vac(vac_v[2]), .ovf(ovf_v[2]),
    .busy(busy2), .pass_cnt(pcnt2), .fail_cnt(fcnt2));

  rep_seq_monitor #(.CNT(3), .MODE(1), .NUM_TRK(4), .TIMEOUT(8), .CW(16)) u_d3 (
    .clk(clk), .rst(rst), .en(en_v[3]), .a(a_v[3]), .b(b_v[3]), .c(c_v[3]),
    .pass(pass_v[3]), .fail(fail_v[3]), .vac(vac_v[3]), .ovf(ovf_v[3]),
    .busy(busy3), .pass_cnt(pcnt3), .fail_cnt(fcnt3));

  rep_seq_monitor #(.CNT(1), .MODE(0), .NUM_TRK(4), .TIMEOUT(64), .CW(2)) u_d4 (
    .clk(clk), .rst(rst), .en(en_v[4]), .a(a_v[4]), .b(b_v[4]), .c(c_v[4]),
    .pass(pass_v[4]), .fail(fail_v[4]), .vac(vac_v[4]), .ovf(ovf_v[4]),
    .busy(busy4), .pass_cnt(pcnt4), .fail_cnt(fcnt4));

  // Count rising edges so outcomes can be matched to the edge that made them.
  always @(posedge clk) begin
    edge_no <= edge_no + 1;
  end

  // Monitor: every outcome pulse must match the next queued expectation.
  // A pulse must come from the right instance, on the right edge, with the
  // right pass/fail/vac mix.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < ND; d++) begin
      if (pass_v[d] | fail_v[d] | vac_v[d]) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("[TB] FAIL outcome_d%0d: got pfv=%b%b%b at edge %0d, required no outcome",
                   d, pass_v[d], fail_v[d], vac_v[d], edge_no);
        end else begin
          e = sbq.pop_front();
          if (e.dut != d || e.edge_at != edge_no ||
              e.p != pass_v[d] || e.f != fail_v[d] || e.v != vac_v[d]) begin
            bad++;
            $display("[TB] FAIL outcome_d%0d: got pfv=%b%b%b at edge %0d, required d%0d pfv=%b%b%b at edge %0d",
                     d, pass_v[d], fail_v[d], vac_v[d], edge_no,
                     e.dut, e.p, e.f, e.v, e.edge_at);
          end
        end
      end
    end
  end

  // Drive one edge's worth of inputs on instance d.
  // Every other instance is left enabled with idle inputs.
  // Returns at the following negedge, where outputs are stable.
  task automatic applyStimulus(input int d, input logic r, input logic e,
                               input logic ai, input logic bi, input logic ci);
    rst     = r;
    en_v    = '1;
    a_v     = '0;
    b_v     = '0;
    c_v     = '0;
    en_v[d] = e;
    a_v[d]  = ai;
    b_v[d]  = bi;
    c_v[d]  = ci;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  // Queue an expected outcome at edge 'rel' counted from the scenario start.
  task automatic expectOut(input int d, input int rel, input logic p,
                           input logic f, input logic v);
    exp_t e;
    e.dut     = d;
    e.edge_at = base + rel;
    e.p       = p;
    e.f       = f;
    e.v       = v;
    sbq.push_back(e);
  endtask

  // One reset edge; relative edge 1 is the edge after it.
  task automatic startScenario();
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    base = edge_no;
  endtask

  initial begin
    rst  = 1'b1;
    en_v = '0;
    a_v  = '0;
    b_v  = '0;
    c_v  = '0;
    @(negedge clk);

    // Reset state.
    startScenario();
    checkOutput("rst_busy0", 32'(busy0), 0);
    checkOutput("rst_pfvo0", 32'({pass_v[0], fail_v[0], vac_v[0], ovf_v[0]}), 0);
    checkOutput("rst_pcnt0", 32'(pcnt0), 0);
    checkOutput("rst_fcnt0", 32'(fcnt0), 0);

    // S1: MODE1 pass through the window on a fourth b.
    $display("[TB] S1 non-consecutive pass");
    expectOut(0, 19, 1'b1, 1'b0, 1'b0);
    for (int r = 1; r <= 22; r++) begin
      applyStimulus(0, 1'b0, 1'b1, r == 10,
                    (r == 12) || (r == 14) || (r == 16) || (r == 19),
                    (r >= 16) && (r <= 18));
      if (r == 18) checkOutput("s1_busy_window", 32'(busy0), 32'h1);
    end
    checkOutput("s1_pass_cnt", 32'(pcnt0), 1);
    checkOutput("s1_fail_cnt", 32'(fcnt0), 0);
    checkOutput("s1_busy_end", 32'(busy0), 0);

    // S2: MODE1, c drops inside the window.
    $display("[TB] S2 non-consecutive window fail");
    startScenario();
    expectOut(0, 17, 1'b0, 1'b1, 1'b0);
    for (int r = 1; r <= 22; r++) begin
      applyStimulus(0, 1'b0, 1'b1, r == 10,
                    (r == 12) || (r == 14) || (r == 16) || (r == 19),
                    (r == 16) || (r == 18));
      if (r == 17) checkOutput("s2_busy_after_fail", 32'(busy0), 0);
    end
    checkOutput("s2_fail_cnt", 32'(fcnt0), 1);
    checkOutput("s2_pass_cnt", 32'(pcnt0), 0);

    // S3: MODE2, a gap in the consecutive run is vacuous.
    $display("[TB] S3 consecutive vacuous");
    startScenario();
    expectOut(1, 13, 1'b0, 1'b0, 1'b1);
    for (int r = 1; r <= 16; r++) begin
      applyStimulus(1, 1'b0, 1'b1, r == 10, (r == 11) || (r == 12), 1'b0);
    end
    checkOutput("s3_pass_cnt", 32'(pcnt1), 0);
    checkOutput("s3_fail_cnt", 32'(fcnt1), 0);
    checkOutput("s3_busy", 32'(busy1), 0);

    // S4: MODE0, all trackers busy, overflow, then a joint pass of four.
    $display("[TB] S4 goto overflow and multi-pass");
    startScenario();
    expectOut(2, 17, 1'b1, 1'b0, 1'b0);
    for (int r = 1; r <= 20; r++) begin
      applyStimulus(2, 1'b0, 1'b1, (r >= 10) && (r <= 14),
                    (r >= 15) && (r <= 17), (r >= 15) && (r <= 17));
      if (r == 14) begin
        checkOutput("s4_busy_full", 32'(busy2), 32'hF);
        checkOutput("s4_ovf", 32'(ovf_v[2]), 1);
      end
    end
    checkOutput("s4_pass_cnt", 32'(pcnt2), 4);
    checkOutput("s4_busy_end", 32'(busy2), 0);
    checkOutput("s4_ovf_sticky", 32'(ovf_v[2]), 1);

    // S5: timeout while counting is vacuous after eight evaluation edges.
    $display("[TB] S5 timeout vacuous");
    startScenario();
    expectOut(3, 18, 1'b0, 1'b0, 1'b1);
    for (int r = 1; r <= 22; r++) begin
      applyStimulus(3, 1'b0, 1'b1, r == 10, 1'b0, 1'b0);
      if (r == 17) checkOutput("s5_busy_pre_timeout", 32'(busy3), 1);
    end
    checkOutput("s5_pass_cnt", 32'(pcnt3), 0);
    checkOutput("s5_busy", 32'(busy3), 0);

    // S6: disable mid-attempt aborts silently.
    $display("[TB] S6 disable");
    startScenario();
    for (int r = 1; r <= 25; r++) begin
      applyStimulus(3, 1'b0, r != 12, r == 10, 1'b0, 1'b0);
      if (r == 11) checkOutput("s6_busy_live", 32'(busy3), 1);
      if (r == 12) checkOutput("s6_busy_disabled", 32'(busy3), 0);
    end
    checkOutput("s6_counts", 32'({pcnt3, fcnt3}), 0);

    // S7: reset with trackers live and counters non-zero.
    $display("[TB] S7 mid-run reset");
    startScenario();
    expectOut(0, 6, 1'b1, 1'b0, 1'b0);
    for (int r = 1; r <= 25; r++) begin
      applyStimulus(0, r == 15, 1'b1, (r == 2) || ((r >= 8) && (r <= 12)),
                    ((r >= 3) && (r <= 6)) || (r >= 16), (r == 5) || (r >= 16));
      if (r == 14) begin
        checkOutput("s7_pcnt_pre", 32'(pcnt0), 1);
        checkOutput("s7_ovf_pre", 32'(ovf_v[0]), 1);
        checkOutput("s7_busy_pre", 32'(busy0), 32'hF);
      end
      if (r == 15) begin
        checkOutput("s7_busy_rst", 32'(busy0), 0);
        checkOutput("s7_pfvo_rst", 32'({pass_v[0], fail_v[0], vac_v[0], ovf_v[0]}), 0);
        checkOutput("s7_pcnt_rst", 32'(pcnt0), 0);
      end
    end
    checkOutput("s7_pcnt_end", 32'(pcnt0), 0);

    // S8: CNT1 latency, same-edge a&b, back-to-back passes, saturation, fail.
    $display("[TB] S8 minimum latency and saturation");
    startScenario();
    expectOut(4, 12, 1'b1, 1'b0, 1'b0);
    for (int k = 21; k <= 25; k++) expectOut(4, k, 1'b1, 1'b0, 1'b0);
    expectOut(4, 31, 1'b0, 1'b1, 1'b0);
    for (int r = 1; r <= 33; r++) begin
      applyStimulus(4, 1'b0, 1'b1,
                    (r == 10) || ((r >= 20) && (r <= 24)) || (r == 30),
                    (r == 10) || (r == 12) || ((r >= 20) && (r <= 25)) || (r == 31),
                    (r == 10) || (r == 12) || ((r >= 20) && (r <= 25)));
      if (r == 10) checkOutput("s8_busy_armed", 32'(busy4), 1);
      if (r == 21) checkOutput("s8_busy_realloc", 32'(busy4), 32'h2);
    end
    checkOutput("s8_pass_sat", 32'(pcnt4), 3);
    checkOutput("s8_fail_cnt", 32'(fcnt4), 1);

    checkOutput("sb_drained", 32'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
